// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported word memory.
// Each access takes IDLE -> SERVE (memory cycle) -> RESP (ack cycle).
module mem_arbiter #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_ack,
    output logic        a_err,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ack,
    output logic        b_err,
    output logic [31:0] b_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        RESP
    } state_t;

    state_t      state_q;
    logic        last_grant_q;  // 1 = B was granted last
    logic        win_q;         // 1 = B owns the access in flight
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic        mem_we_q;
    logic        a_ack_q, b_ack_q;
    logic        a_err_q, b_err_q;
    logic [31:0] a_rdata_q, b_rdata_q;

    logic        grant_b;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;
    logic [31:0] rdata_cap;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        grant_b   = b_req & (~a_req | ~last_grant_q);
        sel_we    = grant_b ? b_we    : a_we;
        sel_addr  = grant_b ? b_addr  : a_addr;
        sel_wdata = grant_b ? b_wdata : a_wdata;
        sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr >= ADDR_LIMIT);
        rdata_cap = err_q ? '0 : mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            win_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            mem_we_q     <= 1'b0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_err_q      <= 1'b0;
            b_err_q      <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    a_ack_q <= 1'b0;
                    b_ack_q <= 1'b0;
                    if (a_req || b_req) begin
                        win_q        <= grant_b;
                        last_grant_q <= grant_b;
                        addr_q       <= sel_addr;
                        wdata_q      <= sel_wdata;
                        err_q        <= sel_err;
                        // Write strobe is registered so it is high exactly for SERVE.
                        mem_we_q     <= sel_we & ~sel_err;
                        state_q      <= SERVE;
                    end
                end
                SERVE: begin
                    mem_we_q <= 1'b0;
                    if (win_q) begin
                        b_rdata_q <= rdata_cap;
                        b_err_q   <= err_q;
                        b_ack_q   <= 1'b1;
                    end else begin
                        a_rdata_q <= rdata_cap;
                        a_err_q   <= err_q;
                        a_ack_q   <= 1'b1;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    a_ack_q <= 1'b0;
                    b_ack_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    mem_we_q <= 1'b0;
                    a_ack_q  <= 1'b0;
                    b_ack_q  <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign a_ack     = a_ack_q;
    assign a_err     = a_err_q;
    assign a_rdata   = a_rdata_q;
    assign b_ack     = b_ack_q;
    assign b_err     = b_err_q;
    assign b_rdata   = b_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_WORDS, default 256, is the number of 32-bit words in the attached memory; the legal byte address range is 0 .. 4*MEM_WORDS-1.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a_req, a_we  input  1 each  requester A (instruction fetch) request and write flag.
REQ-005 a_addr, a_wdata  input  32 each  requester A byte address and write data.
REQ-006 a_ack, a_err  output  1 each  requester A completion pulse and error flag.
REQ-007 a_rdata  output  32  requester A read data.
REQ-008 b_req, b_we, b_addr, b_wdata, b_ack, b_err, b_rdata: the same directions and widths as REQ-004..007, for requester B (data port).
REQ-009 mem_we  output  1  write enable to the memory.
REQ-010 mem_addr, mem_wdata  output  32 each  byte address and write data to the memory.
REQ-011 mem_rdata  input  32  combinational read data from the memory at mem_addr.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, SERVE and RESP; every transition is unconditional except IDLE->SERVE.
REQ-014 IDLE: if a_req or b_req is high, select a winner, latch its we/addr/wdata into internal registers, record the winner, and go to SERVE; otherwise stay in IDLE.
REQ-015 Arbitration is round-robin on a one-bit last_grant: if both requests are high, the requester not equal to last_grant wins; if one request is high, it wins; last_grant updates to the winner.
REQ-016 SERVE lasts exactly 1 cycle: mem_addr = latched addr, mem_wdata = latched wdata, mem_we = latched we AND NOT err.
REQ-017 err = (addr[1:0] != 0) OR (addr >= 4*MEM_WORDS), evaluated on the latched address.
REQ-018 At the edge that ends SERVE: capture rdata = err ? 0 : mem_rdata, capture err, go to RESP.
REQ-019 RESP lasts exactly 1 cycle: the winner's ack = 1, and the winner's rdata and err show the captured values; the other requester's ack = 0. Next state is IDLE.
REQ-020 Outside RESP, a_ack = b_ack = 0; x_rdata and x_err hold the last value captured for that requester.
REQ-021 Latency: request seen in IDLE at cycle N -> memory access in cycle N+1 -> ack in cycle N+2 -> IDLE in N+3. Peak throughput is one access every 3 cycles.
REQ-022 Handshake:
- A requester holds req and its fields stable until it samples ack.
- It deasserts req at the edge that ends the ack cycle, unless it is issuing a new access.
- Request field changes after the IDLE latch edge have no effect on the access in flight.
REQ-023 A req that is asserted while busy is not lost: it is arbitrated in the next IDLE cycle.
REQ-024 A write with err = 1 SHALL NOT assert mem_we; it still completes with ack = 1, err = 1, rdata = 0.
REQ-025 A write returns, in RESP, the mem_rdata sampled during SERVE, which is the pre-write contents of the word.
REQ-026 mem_we SHALL be high for at most one cycle per granted access and never outside SERVE.

Reset
REQ-027 While rst_n = 0, the following hold immediately and independently of clk:
- state = IDLE, last_grant = B (so A wins the first tie).
- latched registers = 0.
- mem_we = 0, mem_addr = 0, mem_wdata = 0.
- a_ack = b_ack = 0, a_err = b_err = 0, a_rdata = b_rdata = 0, busy = 0.
REQ-028 A reset asserted during SERVE or RESP SHALL abort the access: no write occurs after the reset and no ack is issued. Arbitration resumes on the first rising edge after rst_n rises.

Verification
REQ-029 A-only read: preload word 3 = 32'hDEADBEEF; a_req=1, a_addr=12, a_we=0.
- Expect mem_addr=12 one cycle later.
- Expect a_ack=1 and a_rdata=32'hDEADBEEF two cycles after the request, with a_err=0.
- Expect b_ack to stay 0 throughout.
REQ-030 B write then A read of the same word: b_we=1, b_addr=8, b_wdata=32'h12345678, then a_req for addr 8.
- Expect exactly one mem_we pulse.
- Expect a_rdata=32'h12345678.
REQ-031 Both requesters request continuously for 4 accesses right after reset.
- Expect the grant order A, B, A, B.
- Expect acks 3 cycles apart.
REQ-032 Error cases, each completing with ack=1, err=1, rdata=0 and no mem_we pulse:
- b_addr=1024, write.
- a_addr=6 (misaligned).
REQ-033 Reset in the SERVE cycle of a write to addr 4 with data 32'hFFFFFFFF:
- Expect word 1 unchanged, no ack, busy=0 immediately.
- After release, a new request completes normally.
